// File: rtl/maxpool_pkg.sv
//==============================================================================
// Module : maxpool_pkg
// Brief  : Shared sizing helpers and pipeline latency for the serial max-pool.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package maxpool_pkg;

   localparam int LATENCY = 2;

   function automatic int words_per_sample(input int bw_in, input int ser_bw);
      return bw_in / ser_bw;
   endfunction

   function automatic int cntr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ser_deser.sv
//==============================================================================
// Module : ser_deser
// Brief  : LSW-first deserialiser; words enter at the MSB end, full sample is
//          registered on the done strobe.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ser_deser #(
   parameter int BW_IN  = 12,
   parameter int SER_BW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              done,
   input  logic [SER_BW-1:0] din,
   output logic [BW_IN-1:0]  sample
);

   logic [BW_IN-1:0] w_next;

   generate
      if (SER_BW == BW_IN) begin : g_reg
         always_comb w_next = din;
      end else begin : g_shift
         logic [BW_IN-1:0] r_shift;

         // After WPS shifts the first (least significant) word lands at bit 0.
         always_comb w_next = {din, r_shift[BW_IN-1:SER_BW]};

         always_ff @(posedge clk) begin
            if (rst) begin
               r_shift <= '0;
            end else if (load) begin
               r_shift <= w_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sample <= '0;
      end else if (load && done) begin
         sample <= w_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/maxpool_win.sv
//==============================================================================
// Module : maxpool_win
// Brief  : Per-channel non-overlapping max-pool over POOL_K serial samples.
//          Define MAXPOOL_WIN_RELU_EN to clamp negative maxima to zero.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module maxpool_win
   import maxpool_pkg::*;
#(
   parameter int NO_CH  = 10,
   parameter int BW_IN  = 12,
   parameter int SER_BW = 4,
   parameter int POOL_K = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         vld_in,
   input  logic                         sof_in,
   input  logic [NO_CH-1:0][SER_BW-1:0] data_in,
   output logic                         vld_out,
   output logic [NO_CH-1:0][BW_IN-1:0]  data_out
);

   localparam int c_WPS  = words_per_sample(BW_IN, SER_BW);
   localparam int c_WC_W = cntr_w(c_WPS);
   localparam int c_SC_W = cntr_w(POOL_K);
   localparam logic [c_WC_W-1:0] c_WORD_LAST = c_WC_W'(c_WPS - 1);
   localparam logic [c_SC_W-1:0] c_SAMP_LAST = c_SC_W'(POOL_K - 1);

   generate
      if (BW_IN % SER_BW != 0) begin : g_err_bw
         $error("maxpool_win: SER_BW must divide BW_IN");
      end
      if (POOL_K < 2) begin : g_err_k
         $error("maxpool_win: POOL_K must be at least 2");
      end
   endgenerate

   logic [c_WC_W-1:0]            r_word_cnt;
   logic [c_WC_W-1:0]            w_word_idx;
   logic [c_SC_W-1:0]            r_samp_cnt;
   logic [c_SC_W-1:0]            w_samp_idx;
   logic [c_SC_W-1:0]            r_samp_idx;
   logic                         w_last_word;
   logic                         r_samp_vld;
   logic [BW_IN-1:0]             w_sample [NO_CH];
   logic [NO_CH-1:0][BW_IN-1:0]  r_acc;
   logic [NO_CH-1:0][BW_IN-1:0]  w_max;
   logic [NO_CH-1:0][BW_IN-1:0]  w_out;

   // sof_in restarts the frame on the very word it qualifies.
   always_comb begin
      w_word_idx  = sof_in ? '0 : r_word_cnt;
      w_samp_idx  = sof_in ? '0 : r_samp_cnt;
      w_last_word = vld_in && (w_word_idx == c_WORD_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_cnt <= '0;
         r_samp_cnt <= '0;
         r_samp_vld <= 1'b0;
         r_samp_idx <= '0;
      end else begin
         if (vld_in) begin
            r_word_cnt <= w_last_word ? '0 : w_word_idx + c_WC_W'(1);
            if (w_last_word) begin
               r_samp_cnt <= (w_samp_idx == c_SAMP_LAST) ? '0 : w_samp_idx + c_SC_W'(1);
            end else begin
               r_samp_cnt <= w_samp_idx;
            end
         end
         r_samp_vld <= w_last_word;
         r_samp_idx <= w_samp_idx;
      end
   end

   generate
      for (genvar g = 0; g < NO_CH; g++) begin : g_ch
         ser_deser #(
            .BW_IN  (BW_IN),
            .SER_BW (SER_BW)
         ) u_deser (
            .clk    (clk),
            .rst    (rst),
            .load   (vld_in),
            .done   (w_last_word),
            .din    (data_in[g]),
            .sample (w_sample[g])
         );
      end
   endgenerate

   // Ties keep the accumulator; the value is identical either way.
   always_comb begin
      w_max = '0;
      w_out = '0;
      for (int ch = 0; ch < NO_CH; ch++) begin
         w_max[ch] = ($signed(w_sample[ch]) > $signed(r_acc[ch])) ? w_sample[ch] : r_acc[ch];
`ifdef MAXPOOL_WIN_RELU_EN
         w_out[ch] = w_max[ch][BW_IN-1] ? '0 : w_max[ch];
`else
         w_out[ch] = w_max[ch];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         data_out <= '0;
         vld_out  <= 1'b0;
      end else begin
         vld_out <= r_samp_vld && (r_samp_idx == c_SAMP_LAST);
         if (r_samp_vld) begin
            for (int ch = 0; ch < NO_CH; ch++) begin
               r_acc[ch] <= (r_samp_idx == '0) ? w_sample[ch] : w_max[ch];
            end
            if (r_samp_idx == c_SAMP_LAST) begin
               data_out <= w_out;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_win.sv
//==============================================================================
// Module : tb_maxpool_win
// Brief  : Scoreboard bench for maxpool_win: default build plus an unserialised
//          POOL_K=3 instance.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_maxpool_win;
   import maxpool_pkg::*;

   localparam int NCH = 10, BW = 12, SBW = 4, PK = 2, WPS = BW / SBW;
   localparam int NCHB = 2, BWB = 8, PKB = 3;

   typedef logic [NCH-1:0][BW-1:0]   vec_t;
   typedef logic [NCHB-1:0][BWB-1:0] vecb_t;
   typedef struct { vec_t  data; int cyc; } exp_t;
   typedef struct { vecb_t data; int cyc; } expb_t;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        vld_a = 1'b0, sof_a = 1'b0;
   logic [NCH-1:0][SBW-1:0]     din_a = '0;
   logic                        vout_a;
   vec_t                        dout_a;
   logic                        vld_b = 1'b0, sof_b = 1'b0;
   logic [NCHB-1:0][BWB-1:0]    din_b = '0;
   logic                        vout_b;
   vecb_t                       dout_b;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   exp_t  q_a[$];
   expb_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   maxpool_win #(.NO_CH(NCH), .BW_IN(BW), .SER_BW(SBW), .POOL_K(PK)) u_dut_a (
      .clk(clk), .rst(rst), .vld_in(vld_a), .sof_in(sof_a), .data_in(din_a),
      .vld_out(vout_a), .data_out(dout_a));

   maxpool_win #(.NO_CH(NCHB), .BW_IN(BWB), .SER_BW(BWB), .POOL_K(PKB)) u_dut_b (
      .clk(clk), .rst(rst), .vld_in(vld_b), .sof_in(sof_b), .data_in(din_b),
      .vld_out(vout_b), .data_out(dout_b));

   function automatic logic [BW-1:0] relu12(input logic [BW-1:0] v);
`ifdef MAXPOOL_WIN_RELU_EN
      return v[BW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [BWB-1:0] relu8(input logic [BWB-1:0] v);
`ifdef MAXPOOL_WIN_RELU_EN
      return v[BWB-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (vout_a === 1'b1) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_vld_a: got vld_out=1 at cycle %0d expected none", cyc);
         end else begin
            e = q_a.pop_front();
            check("data_a", 128'(dout_a), 128'(e.data));
            check("lat_a", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      expb_t e;
      if (vout_b === 1'b1) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_vld_b: got vld_out=1 at cycle %0d expected none", cyc);
         end else begin
            e = q_b.pop_front();
            check("data_b", 128'(dout_b), 128'(e.data));
            check("lat_b", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle cycle with junk data and a stray sof that must be ignored.
   task automatic idle_a();
      vld_a = 1'b0;
      sof_a = 1'($urandom_range(0, 1));
      din_a = (NCH*SBW)'({$urandom, $urandom});
      tick();
   endtask

   task automatic send_sample_a(input vec_t s, input bit gaps, input bit sof, output int last_cyc);
      int n;
      last_cyc = 0;
      for (int w = 0; w < WPS; w++) begin
         if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) idle_a();
         end
         vld_a = 1'b1;
         sof_a = sof && (w == 0);
         for (int c = 0; c < NCH; c++) din_a[c] = s[c][w*SBW +: SBW];
         last_cyc = cyc;
         tick();
      end
      vld_a = 1'b0;
      sof_a = 1'b0;
   endtask

   task automatic send_window_a(input vec_t s0, input vec_t s1, input bit gaps, input bit sof);
      int   lc;
      vec_t e;
      send_sample_a(s0, gaps, sof, lc);
      send_sample_a(s1, gaps, 1'b0, lc);
      for (int c = 0; c < NCH; c++) begin
         e[c] = ($signed(s1[c]) > $signed(s0[c])) ? s1[c] : s0[c];
         e[c] = relu12(e[c]);
      end
      q_a.push_back('{data: e, cyc: lc + LATENCY});
   endtask

   task automatic send_window_b(input vecb_t s0, input vecb_t s1, input vecb_t s2);
      vecb_t s [PKB];
      vecb_t e;
      int    lc;
      s[0] = s0; s[1] = s1; s[2] = s2;
      lc = 0;
      for (int k = 0; k < PKB; k++) begin
         vld_b = 1'b1;
         din_b = s[k];
         lc = cyc;
         tick();
      end
      vld_b = 1'b0;
      e = s0;
      for (int k = 1; k < PKB; k++)
         for (int c = 0; c < NCHB; c++)
            if ($signed(s[k][c]) > $signed(e[c])) e[c] = s[k][c];
      for (int c = 0; c < NCHB; c++) e[c] = relu8(e[c]);
      q_b.push_back('{data: e, cyc: lc + LATENCY});
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
      repeat (4) tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      vec_t s0, s1;
      int   lc;

      repeat (3) tick();
      @(negedge clk);
      check("reset_vld_a", 128'(vout_a), 128'(0));
      check("reset_data_a", 128'(dout_a), 128'(0));
      check("reset_vld_b", 128'(vout_b), 128'(0));
      check("reset_data_b", 128'(dout_b), 128'(0));
      rst = 1'b0;
      tick();

      // Hand-picked first window: 5/-3, -7/-2, tie, extremes both ways.
      for (int c = 0; c < NCH; c++) begin
         s0[c] = BW'(c * 151 - 700);
         s1[c] = BW'(300 - c * 97);
      end
      s0[0] = 12'h005; s1[0] = 12'hFFD;
      s0[1] = 12'hFF9; s1[1] = 12'hFFE;
      s0[2] = 12'h123; s1[2] = 12'h123;
      s0[3] = 12'h800; s1[3] = 12'h7FF;
      s0[4] = 12'h7FF; s1[4] = 12'h800;
      send_window_a(s0, s1, 1'b0, 1'b0);

      // Three back-to-back windows with random idle gaps between words.
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < NCH; c++) begin
            s0[c] = BW'((k * 7 + c) * 193 - 1000);
            s1[c] = BW'(1500 - (k * 5 + c) * 211);
         end
         send_window_a(s0, s1, 1'b1, 1'b0);
      end

      // Two windows at full rate.
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NCH; c++) begin
            s0[c] = BW'(c * 300 - 1800 + k);
            s1[c] = BW'(-c * 250 + 900 - k);
         end
         send_window_a(s0, s1, 1'b0, 1'b0);
      end

      // Abort: full sample 0 of max value, one stray word, then sof restart.
      for (int c = 0; c < NCH; c++) s0[c] = 12'h7FF;
      send_sample_a(s0, 1'b0, 1'b0, lc);
      vld_a = 1'b1;
      din_a = (NCH*SBW)'({$urandom, $urandom});
      tick();
      for (int c = 0; c < NCH; c++) begin
         s0[c] = BW'(c * 40 - 200);
         s1[c] = BW'(-c * 60 + 150);
      end
      send_window_a(s0, s1, 1'b0, 1'b1);
      drain();

      // Reset in the middle of a sample.
      for (int w = 0; w < 2; w++) begin
         vld_a = 1'b1;
         din_a = (NCH*SBW)'({$urandom, $urandom});
         tick();
      end
      vld_a = 1'b0;
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_vld_a", 128'(vout_a), 128'(0));
      check("midrst_data_a", 128'(dout_a), 128'(0));
      rst = 1'b0;
      tick();
      for (int c = 0; c < NCH; c++) begin
         s0[c] = BW'(c * 111 - 555);
         s1[c] = BW'(c * 77 - 333);
      end
      send_window_a(s0, s1, 1'b0, 1'b0);

      // Unserialised instance: three windows at full rate with 8-bit extremes.
      send_window_b({8'h80, 8'h7F}, {8'h80, 8'h80}, {8'h80, 8'h00});
      send_window_b({8'h00, 8'h80}, {8'h7F, 8'hFF}, {8'h05, 8'hFE});
      send_window_b({8'h9C, 8'hFB}, {8'h80, 8'hFB}, {8'h9D, 8'hFB});
      drain();

      check("pending_a", 128'(q_a.size()), 128'(0));
      check("pending_b", 128'(q_b.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
